// File: rtl/snake_pkg.sv
// Shared types for the snake game engine.
//   dir_t      : movement direction encoding used on i_dir[1:0]
//   state_t    : engine FSM states
//   is_reverse : true when two directions point opposite ways
package snake_pkg;

  typedef enum logic [1:0] {
    UP    = 2'b00,
    DOWN  = 2'b01,
    LEFT  = 2'b10,
    RIGHT = 2'b11
  } dir_t;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    FOOD = 2'b10,
    DONE = 2'b11
  } state_t;

  // Opposite pairs share bit 1 and differ in bit 0 (UP/DOWN, LEFT/RIGHT).
  function automatic logic is_reverse(dir_t a, dir_t b);
    return (a[1] == b[1]) && (a[0] != b[0]);
  endfunction

endpackage

// File: rtl/snake_tick_gen.sv
// Move-rate divider: one-cycle o_tick every TICK_DIV enabled cycles.
//   i_clk  : clock
//   i_rst  : asynchronous reset, active-low
//   i_en   : count enable; the count holds while low
//   o_tick : high on the enabled cycle where the count reaches TICK_DIV-1
module snake_tick_gen #(
  parameter int unsigned TICK_DIV = 4
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_en,
  output logic o_tick
);

  localparam int unsigned CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  logic [CW-1:0] cnt_q, cnt_d;
  logic          tick_c;

  // Wrapping counter, paused when disabled.
  always_comb begin
    cnt_d  = cnt_q;
    tick_c = 1'b0;
    if (i_en) begin
      if (cnt_q == CW'(TICK_DIV - 1)) begin
        cnt_d  = '0;
        tick_c = 1'b1;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign o_tick = tick_c;

endmodule

// File: rtl/snake_engine.sv
// Snake game-state engine: direction latch, timed movement, food placement,
// wall/self collision, win detection and a registered cell-query port.
//   i_clk, i_rst        : clock, asynchronous active-low reset
//   i_dir               : [2]=1 no command, else [1:0] direction
//   i_restart           : restart pulse, only acted on after game over
//   i_rand              : free-running random source for food placement
//   i_qx, i_qy          : renderer query coordinate
//   o_q_body, o_q_food  : query result, one cycle after the coordinate
//   o_head_x, o_head_y  : head coordinate
//   o_size              : current body length
//   o_done, o_win       : game over, and game over by reaching MAX_LEN
module snake_engine #(
  parameter  int unsigned GRID_W   = 16,
  parameter  int unsigned GRID_H   = 16,
  parameter  int unsigned MAX_LEN  = 16,
  parameter  int unsigned INIT_LEN = 3,
  parameter  int unsigned TICK_DIV = 4,
  localparam int unsigned XW       = $clog2(GRID_W),
  localparam int unsigned YW       = $clog2(GRID_H),
  localparam int unsigned SW       = $clog2(MAX_LEN + 1)
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic [2:0]    i_dir,
  input  logic          i_restart,
  input  logic [15:0]   i_rand,
  input  logic [XW-1:0] i_qx,
  input  logic [YW-1:0] i_qy,
  output logic          o_q_body,
  output logic          o_q_food,
  output logic [XW-1:0] o_head_x,
  output logic [YW-1:0] o_head_y,
  output logic [SW-1:0] o_size,
  output logic          o_done,
  output logic          o_win
);

  import snake_pkg::*;

  // Reset/restart layout: horizontal line ending at the grid centre.
  function automatic logic [XW-1:0] init_x(int unsigned k);
    return XW'(GRID_W / 2 - k);
  endfunction

  state_t        state_q, state_d;
  dir_t          cur_dir_q, cur_dir_d;
  dir_t          pend_dir_q, pend_dir_d;
  logic [XW-1:0] seg_x_q [MAX_LEN];
  logic [XW-1:0] seg_x_d [MAX_LEN];
  logic [YW-1:0] seg_y_q [MAX_LEN];
  logic [YW-1:0] seg_y_d [MAX_LEN];
  logic [SW-1:0] size_q, size_d;
  logic [XW-1:0] food_x_q, food_x_d;
  logic [YW-1:0] food_y_q, food_y_d;
  logic          done_q, done_d;
  logic          win_q, win_d;
  logic          q_body_q, q_body_d;
  logic          q_food_q, q_food_d;

  logic          run_c;
  logic          tick_c;
  logic [XW-1:0] nx_x_c, cand_x_c, cmp_x_c;
  logic [YW-1:0] nx_y_c, cand_y_c, cmp_y_c;
  logic          wall_c;
  logic [MAX_LEN-1:0] hit_c, qhit_c, live_c, body_c;
  logic          unused_rand;

  assign run_c = (state_q == RUN);

  snake_tick_gen #(
    .TICK_DIV (TICK_DIV)
  ) u_tick (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_en   (run_c),
    .o_tick (tick_c)
  );

  // Next head for the direction taking effect on this tick, plus wall test.
  always_comb begin
    nx_x_c = seg_x_q[0];
    nx_y_c = seg_y_q[0];
    wall_c = 1'b0;
    case (pend_dir_q)
      UP: begin
        wall_c = (seg_y_q[0] == '0);
        nx_y_c = seg_y_q[0] - YW'(1);
      end
      DOWN: begin
        wall_c = (seg_y_q[0] == YW'(GRID_H - 1));
        nx_y_c = seg_y_q[0] + YW'(1);
      end
      LEFT: begin
        wall_c = (seg_x_q[0] == '0);
        nx_x_c = seg_x_q[0] - XW'(1);
      end
      default: begin
        wall_c = (seg_x_q[0] == XW'(GRID_W - 1));
        nx_x_c = seg_x_q[0] + XW'(1);
      end
    endcase
  end

  assign cand_x_c    = i_rand[XW-1:0];
  assign cand_y_c    = i_rand[8 +: YW];
  assign unused_rand = ^i_rand;

  // RUN and FOOD never overlap, so one comparator bank serves both checks.
  assign cmp_x_c = (state_q == FOOD) ? cand_x_c : nx_x_c;
  assign cmp_y_c = (state_q == FOOD) ? cand_y_c : nx_y_c;

  // Per-segment comparators; live masks stale entries, body also drops the tail.
  for (genvar k = 0; k < MAX_LEN; k++) begin : g_cmp
    assign hit_c[k]  = (seg_x_q[k] == cmp_x_c) && (seg_y_q[k] == cmp_y_c);
    assign qhit_c[k] = (seg_x_q[k] == i_qx) && (seg_y_q[k] == i_qy);
    assign live_c[k] = (SW'(k) < size_q);
    assign body_c[k] = (SW'(k + 1) < size_q);
  end

  // Next-state and datapath update.
  always_comb begin
    state_d    = state_q;
    cur_dir_d  = cur_dir_q;
    pend_dir_d = pend_dir_q;
    seg_x_d    = seg_x_q;
    seg_y_d    = seg_y_q;
    size_d     = size_q;
    food_x_d   = food_x_q;
    food_y_d   = food_y_q;
    done_d     = done_q;
    win_d      = win_q;
    q_body_d   = |(qhit_c & live_c);
    q_food_d   = (i_qx == food_x_q) && (i_qy == food_y_q);

    case (state_q)
      IDLE: begin
        if (!i_dir[2]) begin
          cur_dir_d  = dir_t'(i_dir[1:0]);
          pend_dir_d = dir_t'(i_dir[1:0]);
          state_d    = RUN;
        end
      end

      RUN: begin
        // On a tick the pending direction becomes current, so filter against it.
        if (!i_dir[2] &&
            !is_reverse(dir_t'(i_dir[1:0]), tick_c ? pend_dir_q : cur_dir_q)) begin
          pend_dir_d = dir_t'(i_dir[1:0]);
        end
        if (tick_c) begin
          cur_dir_d = pend_dir_q;
          if (wall_c || (|(hit_c & body_c))) begin
            state_d = DONE;
            done_d  = 1'b1;
          end else begin
            seg_x_d[0] = nx_x_c;
            seg_y_d[0] = nx_y_c;
            for (int unsigned k = 1; k < MAX_LEN; k++) begin
              seg_x_d[k] = seg_x_q[k-1];
              seg_y_d[k] = seg_y_q[k-1];
            end
            if ((nx_x_c == food_x_q) && (nx_y_c == food_y_q)) begin
              size_d = size_q + SW'(1);
              if (size_q == SW'(MAX_LEN - 1)) begin
                state_d = DONE;
                done_d  = 1'b1;
                win_d   = 1'b1;
              end else begin
                state_d = FOOD;
              end
            end
          end
        end
      end

      FOOD: begin
        if (!(|(hit_c & live_c))) begin
          food_x_d = cand_x_c;
          food_y_d = cand_y_c;
          state_d  = RUN;
        end
      end

      default: begin
        if (i_restart) begin
          state_d    = IDLE;
          cur_dir_d  = RIGHT;
          pend_dir_d = RIGHT;
          for (int unsigned k = 0; k < MAX_LEN; k++) begin
            seg_x_d[k] = init_x(k);
            seg_y_d[k] = YW'(GRID_H / 2);
          end
          size_d   = SW'(INIT_LEN);
          food_x_d = XW'(GRID_W / 2 + 4);
          food_y_d = YW'(GRID_H / 2);
          done_d   = 1'b0;
          win_d    = 1'b0;
        end
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state_q    <= IDLE;
      cur_dir_q  <= RIGHT;
      pend_dir_q <= RIGHT;
      for (int unsigned k = 0; k < MAX_LEN; k++) begin
        seg_x_q[k] <= init_x(k);
        seg_y_q[k] <= YW'(GRID_H / 2);
      end
      size_q   <= SW'(INIT_LEN);
      food_x_q <= XW'(GRID_W / 2 + 4);
      food_y_q <= YW'(GRID_H / 2);
      done_q   <= 1'b0;
      win_q    <= 1'b0;
      q_body_q <= 1'b0;
      q_food_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cur_dir_q  <= cur_dir_d;
      pend_dir_q <= pend_dir_d;
      seg_x_q    <= seg_x_d;
      seg_y_q    <= seg_y_d;
      size_q     <= size_d;
      food_x_q   <= food_x_d;
      food_y_q   <= food_y_d;
      done_q     <= done_d;
      win_q      <= win_d;
      q_body_q   <= q_body_d;
      q_food_q   <= q_food_d;
    end
  end

  assign o_q_body = q_body_q;
  assign o_q_food = q_food_q;
  assign o_head_x = seg_x_q[0];
  assign o_head_y = seg_y_q[0];
  assign o_size   = size_q;
  assign o_done   = done_q;
  assign o_win    = win_q;

endmodule

// File: tb/tb_snake_engine.sv
// Bench for snake_engine: a default instance plus a MAX_LEN=5 instance fed
// the same stimulus, so the short one wins where the default one keeps going.
module tb_snake_engine;

  logic        clk;
  logic        rst_n;
  logic [2:0]  i_dir;
  logic        i_restart;
  logic [15:0] i_rand;
  logic [3:0]  i_qx, i_qy;

  logic       a_qb, a_qf, a_done, a_win;
  logic [3:0] a_hx, a_hy;
  logic [4:0] a_size;
  logic       b_qb, b_qf, b_done, b_win;
  logic [3:0] b_hx, b_hy;
  logic [2:0] b_size;

  snake_engine dut (
    .i_clk(clk), .i_rst(rst_n), .i_dir(i_dir), .i_restart(i_restart),
    .i_rand(i_rand), .i_qx(i_qx), .i_qy(i_qy),
    .o_q_body(a_qb), .o_q_food(a_qf), .o_head_x(a_hx), .o_head_y(a_hy),
    .o_size(a_size), .o_done(a_done), .o_win(a_win)
  );

  snake_engine #(.MAX_LEN(5)) dut_win (
    .i_clk(clk), .i_rst(rst_n), .i_dir(i_dir), .i_restart(i_restart),
    .i_rand(i_rand), .i_qx(i_qx), .i_qy(i_qy),
    .o_q_body(b_qb), .o_q_food(b_qf), .o_head_x(b_hx), .o_head_y(b_hy),
    .o_size(b_size), .o_done(b_done), .o_win(b_win)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  typedef struct {
    string nm;
    logic  b, f, b2, f2;
  } sb_t;
  sb_t sb[$];

  typedef struct packed {
    logic [3:0] x, y;
    logic       b, f;
  } qvec_t;
  qvec_t tbl[8];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Drive a query, queue the expected answer, compare when the register updates.
  task automatic do_query(input string nm, input logic [3:0] x, input logic [3:0] y,
                          input logic b, input logic f, input logic b2, input logic f2);
    sb_t e;
    i_qx = x;
    i_qy = y;
    e.nm = nm; e.b = b; e.f = f; e.b2 = b2; e.f2 = f2;
    sb.push_back(e);
    step(1);
    e = sb.pop_front();
    chk({e.nm, ".body"}, 32'(a_qb), 32'(e.b));
    chk({e.nm, ".food"}, 32'(a_qf), 32'(e.f));
    chk({e.nm, ".body2"}, 32'(b_qb), 32'(e.b2));
    chk({e.nm, ".food2"}, 32'(b_qf), 32'(e.f2));
  endtask

  task automatic chk_head(input string nm, input int x, input int y);
    chk({nm, ".hx"}, 32'(a_hx), 32'(x));
    chk({nm, ".hy"}, 32'(a_hy), 32'(y));
  endtask

  task automatic pulse_dir(input logic [2:0] d);
    i_dir = d;
    step(1);
    i_dir = 3'b100;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0; i_dir = 3'b100; i_restart = 1'b0;
    i_rand = 16'h0302; i_qx = 4'd8; i_qy = 4'd8;

    tbl[0] = '{x: 4'd8,  y: 4'd8,  b: 1'b1, f: 1'b0};
    tbl[1] = '{x: 4'd7,  y: 4'd8,  b: 1'b1, f: 1'b0};
    tbl[2] = '{x: 4'd6,  y: 4'd8,  b: 1'b1, f: 1'b0};
    tbl[3] = '{x: 4'd5,  y: 4'd8,  b: 1'b0, f: 1'b0};
    tbl[4] = '{x: 4'd12, y: 4'd8,  b: 1'b0, f: 1'b1};
    tbl[5] = '{x: 4'd9,  y: 4'd8,  b: 1'b0, f: 1'b0};
    tbl[6] = '{x: 4'd8,  y: 4'd7,  b: 1'b0, f: 1'b0};
    tbl[7] = '{x: 4'd15, y: 4'd15, b: 1'b0, f: 1'b0};

    // Reset values while reset is held.
    step(3);
    chk_head("rst", 8, 8);
    chk("rst.size", 32'(a_size), 32'd3);
    chk("rst.done", 32'(a_done), 32'd0);
    chk("rst.win", 32'(a_win), 32'd0);
    chk("rst.qbody", 32'(a_qb), 32'd0);
    chk("rst.qfood", 32'(a_qf), 32'd0);

    // T1: idle with no command, nothing moves.
    rst_n = 1'b1;
    step(20);
    chk_head("idle", 8, 8);
    chk("idle.size", 32'(a_size), 32'd3);
    chk("idle.done", 32'(a_done), 32'd0);

    for (int i = 0; i < 8; i++)
      do_query($sformatf("idleq%0d", i), tbl[i].x, tbl[i].y,
               tbl[i].b, tbl[i].f, tbl[i].b, tbl[i].f);

    // T2: move right, one cell per 4 cycles, eat at (12,8), food re-placed at (2,3).
    pulse_dir(3'b011);
    step(4);  chk_head("mv1", 9, 8);
    step(4);  chk_head("mv2", 10, 8);
    step(4);  chk_head("mv3", 11, 8);
    chk("mv3.size", 32'(a_size), 32'd3);
    step(4);  chk_head("eat", 12, 8);
    chk("eat.size", 32'(a_size), 32'd4);
    step(1);
    do_query("food23", 4'd2, 4'd3, 1'b0, 1'b1, 1'b0, 1'b1);
    do_query("head12", 4'd12, 4'd8, 1'b1, 1'b0, 1'b1, 1'b0);

    // T3: reversal ignored; restart outside DONE ignored.
    i_restart = 1'b1;
    pulse_dir(3'b010);
    i_restart = 1'b0;
    step(1);
    chk_head("rev", 13, 8);
    chk("rev.size", 32'(a_size), 32'd4);
    chk("rev.done", 32'(a_done), 32'd0);

    // T4: run into the right wall.
    step(4);  chk_head("w14", 14, 8);
    step(4);  chk_head("w15", 15, 8);
    chk("w15.done", 32'(a_done), 32'd0);
    step(4);
    chk("wall.done", 32'(a_done), 32'd1);
    chk("wall.win", 32'(a_win), 32'd0);
    chk_head("wall", 15, 8);
    step(6);
    chk_head("frozen", 15, 8);
    chk("frozen.size", 32'(a_size), 32'd4);
    do_query("dq15", 4'd15, 4'd8, 1'b1, 1'b0, 1'b1, 1'b0);
    do_query("dq12", 4'd12, 4'd8, 1'b1, 1'b0, 1'b1, 1'b0);
    do_query("dq11", 4'd11, 4'd8, 1'b0, 1'b0, 1'b0, 1'b0);
    do_query("dq23", 4'd2, 4'd3, 1'b0, 1'b1, 1'b0, 1'b1);

    // Restart from DONE.
    i_restart = 1'b1;
    step(1);
    i_restart = 1'b0;
    chk_head("rs", 8, 8);
    chk("rs.size", 32'(a_size), 32'd3);
    chk("rs.done", 32'(a_done), 32'd0);

    // T5/T6: grow to 5 (short instance wins), then down, left, up self-hit.
    i_rand = 16'h080D;
    pulse_dir(3'b011);
    step(4);  chk_head("g9", 9, 8);
    step(12); chk_head("g12", 12, 8);
    chk("g12.size", 32'(a_size), 32'd4);
    step(1);
    i_rand = 16'h080C;          // first candidate lands on the body
    step(4);
    chk_head("g13", 13, 8);
    chk("g13.size", 32'(a_size), 32'd5);
    chk("win.done", 32'(b_done), 32'd1);
    chk("win.win", 32'(b_win), 32'd1);
    chk("win.size", 32'(b_size), 32'd5);
    chk("win.hx", 32'(b_hx), 32'd13);
    step(1);
    i_rand = 16'h0000;
    step(1);
    pulse_dir(3'b001);
    step(3);  chk_head("down", 13, 9);
    pulse_dir(3'b010);
    step(3);  chk_head("left", 12, 9);
    chk("left.done", 32'(a_done), 32'd0);
    pulse_dir(3'b000);
    step(3);
    chk("self.done", 32'(a_done), 32'd1);
    chk("self.win", 32'(a_win), 32'd0);
    chk_head("self", 12, 9);
    chk("self.size", 32'(a_size), 32'd5);
    do_query("sq00", 4'd0,  4'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    do_query("sq12", 4'd12, 4'd8, 1'b1, 1'b0, 1'b1, 1'b0);
    do_query("sq11", 4'd11, 4'd8, 1'b1, 1'b0, 1'b1, 1'b0);
    do_query("sq10", 4'd10, 4'd8, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("win.hold", 32'(b_win), 32'd1);

    // Restart both; short instance back to initial layout.
    i_restart = 1'b1;
    step(1);
    i_restart = 1'b0;
    chk("rs2.size", 32'(b_size), 32'd3);
    chk("rs2.done", 32'(b_done), 32'd0);
    chk("rs2.win", 32'(b_win), 32'd0);
    chk("rs2.hx", 32'(b_hx), 32'd8);
    do_query("rq78", 4'd7,  4'd8, 1'b1, 1'b0, 1'b1, 1'b0);
    do_query("rq128", 4'd12, 4'd8, 1'b0, 1'b1, 1'b0, 1'b1);
    do_query("rq58", 4'd5,  4'd8, 1'b0, 1'b0, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
